// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and
// long-latency results are queued in a small FIFO that drains into idle write slots.
module rf_writeback_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [4:0]               mc_rd,
    input  logic [XLEN-1:0]          mc_data,
    output logic                     we3,
    output logic [4:0]               a3,
    output logic [XLEN-1:0]          wd3,
    output logic [31:0]              pend_mask,
    output logic                     drain_req,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   starve_cnt;

    logic wb_hit, fifo_empty, fifo_full, push, pop;

    assign wb_hit     = wb_we && (wb_rd != 5'd0);
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == CW'(DEPTH));
    assign mc_ready   = !reset && !fifo_full;
    // Results for x0 complete the handshake but are never queued.
    assign push       = mc_valid && mc_ready && (mc_rd != 5'd0);
    assign pop        = !reset && !wb_hit && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            vld        <= '0;
            starve_cnt <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= mc_rd;
            data_mem[wr_ptr] <= mc_data;
        end
    end

    always_comb begin
        we3       = 1'b0;
        a3        = '0;
        wd3       = '0;
        pend_mask = '0;
        drain_req = 1'b0;
        fifo_cnt  = '0;
        if (!reset) begin
            if (wb_hit) begin
                we3 = 1'b1;
                a3  = wb_rd;
                wd3 = wb_data;
            end else if (!fifo_empty) begin
                we3 = 1'b1;
                a3  = rd_mem[rd_ptr];
                wd3 = data_mem[rd_ptr];
            end
            for (int unsigned i = 0; i < DEPTH; i++)
                if (vld[i]) pend_mask[rd_mem[i]] = 1'b1;
            drain_req = (starve_cnt == SW'(STARVE_MAX));
            fifo_cnt  = cnt;
        end
    end

endmodule
